// File: rtl/frame_seq_pkg.sv
// Shared types and length/row helpers for the frame sequencer.
// The package constants describe the default 540x540, 3-row-window frame.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL1  = 3'd1,
    ST_RUN1  = 3'd2,
    ST_SEL2  = 3'd3,
    ST_FETCH = 3'd4,
    ST_CORE  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } fs_state_e;

  function automatic int calc_mode1_len(int rows, int cols);
    return rows * cols;
  endfunction

  function automatic int calc_first_fetch_len(int win, int cols);
    return win * cols;
  endfunction

  function automatic int calc_next_fetch_len(int cols);
    return cols;
  endfunction

  function automatic int calc_last_row(int rows, int win);
    return rows - win;
  endfunction

  localparam int IMG_ROWS_DEF = 540;
  localparam int IMG_COLS_DEF = 540;
  localparam int WIN_DEF      = 3;

  localparam int MODE1_LEN       = calc_mode1_len(IMG_ROWS_DEF, IMG_COLS_DEF);
  localparam int FIRST_FETCH_LEN = calc_first_fetch_len(WIN_DEF, IMG_COLS_DEF);
  localparam int NEXT_FETCH_LEN  = calc_next_fetch_len(IMG_COLS_DEF);
  localparam int LAST_ROW        = calc_last_row(IMG_ROWS_DEF, WIN_DEF);

endpackage

// File: rtl/frame_seq_controller_watchdog.sv
// Run-state watchdog: timeout fires on the TIMEOUT_CYC-th enabled cycle since
// the last clear, so a run state may occupy at most TIMEOUT_CYC cycles.
module seq_watchdog #(
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);
  localparam bit ENABLED = (TIMEOUT_CYC != 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && ENABLED && cnt != LIMIT)
      cnt <= cnt + CW'(1);
  end

  assign timeout = ENABLED && en && (cnt == LIMIT);

endmodule

// File: rtl/frame_seq_controller.sv
// Image pipeline sequencer: bulk copy (mode 1) or row-window processing
// (mode 2), with start-edge detect, abort, watchdog and status outputs.
module frame_seq_controller
  import frame_seq_pkg::*;
#(
  parameter int IMG_ROWS    = 540,
  parameter int IMG_COLS    = 540,
  parameter int WIN         = 3,
  parameter int LEN_W       = 20,
  parameter int ROW_W       = 10,
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode1_sel_i,
  input  logic             mode2_sel_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode1_done_i,
  input  logic             fetch_done_i,
  input  logic             core_done_i,
  output logic             is_mode1_o,
  output logic             is_mode2_o,
  output logic             mode1_run_o,
  output logic             fetch_run_o,
  output logic             core_run_o,
  output logic [LEN_W-1:0] cnt_len_o,
  output logic [ROW_W-1:0] cnt_img_row_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       state_o
);

  localparam logic [LEN_W-1:0] M1_LEN  = LEN_W'(calc_mode1_len(IMG_ROWS, IMG_COLS));
  localparam logic [LEN_W-1:0] FF_LEN  = LEN_W'(calc_first_fetch_len(WIN, IMG_COLS));
  localparam logic [LEN_W-1:0] NF_LEN  = LEN_W'(calc_next_fetch_len(IMG_COLS));
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(calc_last_row(IMG_ROWS, WIN));

  fs_state_e        state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic             first, first_nxt;
  logic             start_q, start_rise;
  logic             in_run, timeout, wd_clr;
  logic             lv_m1_only, lv_m2_only, lv_none;

  assign start_rise = start_i & ~start_q;
  assign lv_m1_only = mode1_sel_i & ~mode2_sel_i;
  assign lv_m2_only = ~mode1_sel_i & mode2_sel_i;
  assign lv_none    = ~mode1_sel_i & ~mode2_sel_i;
  assign in_run     = (state == ST_RUN1) || (state == ST_FETCH) || (state == ST_CORE);
  assign wd_clr     = (state_nxt != state);

  seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (in_run),
    .timeout (timeout)
  );

  // Run states resolve abort, then their done input, then timeout.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    first_nxt = first;
    case (state)
      ST_IDLE: begin
        if (lv_m1_only)      state_nxt = ST_SEL1;
        else if (lv_m2_only) state_nxt = ST_SEL2;
      end
      ST_SEL1: begin
        if (start_rise)      state_nxt = ST_RUN1;
        else if (lv_m2_only) state_nxt = ST_SEL2;
        else if (lv_none)    state_nxt = ST_IDLE;
      end
      ST_SEL2: begin
        if (start_rise) begin
          state_nxt = ST_FETCH;
          row_nxt   = '0;
          first_nxt = 1'b1;
        end
        else if (lv_m1_only) state_nxt = ST_SEL1;
        else if (lv_none)    state_nxt = ST_IDLE;
      end
      ST_RUN1: begin
        if (abort_i)           state_nxt = ST_IDLE;
        else if (mode1_done_i) state_nxt = ST_DONE;
        else if (timeout)      state_nxt = ST_ERR;
      end
      ST_FETCH: begin
        if (abort_i) state_nxt = ST_IDLE;
        else if (fetch_done_i) begin
          state_nxt = ST_CORE;
          first_nxt = 1'b0;
        end
        else if (timeout) state_nxt = ST_ERR;
      end
      ST_CORE: begin
        if (abort_i) state_nxt = ST_IDLE;
        else if (core_done_i) begin
          if (row == ROW_END) state_nxt = ST_DONE;
          else begin
            state_nxt = ST_FETCH;
            row_nxt   = row + ROW_W'(1);
          end
        end
        else if (timeout) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR: begin
        if (start_rise || lv_none) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      row     <= '0;
      first   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      first   <= first_nxt;
      start_q <= start_i;
    end
  end

  always_comb begin
    is_mode1_o  = 1'b0;
    is_mode2_o  = 1'b0;
    mode1_run_o = 1'b0;
    fetch_run_o = 1'b0;
    core_run_o  = 1'b0;
    cnt_len_o   = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      ST_SEL1: is_mode1_o = 1'b1;
      ST_SEL2: is_mode2_o = 1'b1;
      ST_RUN1: begin
        is_mode1_o  = 1'b1;
        mode1_run_o = 1'b1;
        cnt_len_o   = M1_LEN;
      end
      ST_FETCH: begin
        is_mode2_o  = 1'b1;
        fetch_run_o = 1'b1;
        cnt_len_o   = first ? FF_LEN : NF_LEN;
      end
      ST_CORE: begin
        is_mode2_o = 1'b1;
        core_run_o = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      ST_ERR:  err_o  = 1'b1;
      default: ;
    endcase
  end

  assign busy_o        = in_run;
  assign cnt_img_row_o = row;
  assign state_o       = state;

endmodule

// File: tb/tb_frame_seq_controller.sv
// Directed bench for frame_seq_controller on an 8x4 frame, 3-row window,
// 16-cycle watchdog: a vector table plus hand sequences for corner cases.
module tb_frame_seq_controller;

  localparam logic [6:0] M1 = 7'b1000000, M2 = 7'b0100000, ST = 7'b0010000,
                         AB = 7'b0001000, MD = 7'b0000100, FD = 7'b0000010,
                         CD = 7'b0000001;
  // flags = {is_mode1, is_mode2, mode1_run, fetch_run, core_run}
  localparam logic [4:0] F_NONE = 5'b00000, F_SEL1 = 5'b10000, F_RUN1 = 5'b10100,
                         F_SEL2 = 5'b01000, F_FETCH = 5'b01010, F_CORE = 5'b01001;

  typedef struct {
    logic [6:0] in;
    logic [2:0] st;
    logic [4:0] fl;
    logic [7:0] len;
    logic [3:0] row;
    logic [2:0] dbe;  // {done, busy, err}
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic m1 = 0, m2 = 0, start = 0, abort = 0, m1d = 0, fd = 0, cd = 0;
  logic is_m1, is_m2, m1run, frun, crun, busy, done, err;
  logic [7:0] len;
  logic [3:0] row;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  frame_seq_controller #(
    .IMG_ROWS(8), .IMG_COLS(4), .WIN(3), .LEN_W(8), .ROW_W(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .mode1_sel_i(m1), .mode2_sel_i(m2), .start_i(start), .abort_i(abort),
    .mode1_done_i(m1d), .fetch_done_i(fd), .core_done_i(cd),
    .is_mode1_o(is_m1), .is_mode2_o(is_m2), .mode1_run_o(m1run),
    .fetch_run_o(frun), .core_run_o(crun), .cnt_len_o(len),
    .cnt_img_row_o(row), .busy_o(busy), .done_o(done), .err_o(err),
    .state_o(state)
  );

  function automatic vec_t mk(logic [6:0] in, logic [2:0] st, logic [4:0] fl,
                              logic [7:0] ln, logic [3:0] rw, logic [2:0] dbe);
    vec_t v;
    v.in = in; v.st = st; v.fl = fl; v.len = ln; v.row = rw; v.dbe = dbe;
    return v;
  endfunction

  task automatic drive(input logic [6:0] in);
    {m1, m2, start, abort, m1d, fd, cd} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".state"}, 32'(state), 32'(v.st));
    chk({tag, ".flags"}, 32'({is_m1, is_m2, m1run, frun, crun}), 32'(v.fl));
    chk({tag, ".len"}, 32'(len), 32'(v.len));
    chk({tag, ".row"}, 32'(row), 32'(v.row));
    chk({tag, ".dbe"}, 32'({done, busy, err}), 32'(v.dbe));
  endtask

  task automatic step(input string tag, input vec_t v);
    drive(v.in);
    tick();
    chk_all(tag, v);
  endtask

  initial begin
    // Mode 1 path, lever juggling, then a full mode-2 frame.
    vecs.push_back(mk(M1,         3'd1, F_SEL1, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M1|M2,      3'd1, F_SEL1, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M1|ST,      3'd2, F_RUN1, 8'd32, 4'd0, 3'b010));
    vecs.push_back(mk(M2|FD|CD,   3'd2, F_RUN1, 8'd32, 4'd0, 3'b010));
    vecs.push_back(mk(M1|MD,      3'd6, F_NONE, 8'd0,  4'd0, 3'b100));
    vecs.push_back(mk(7'd0,       3'd0, F_NONE, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M2,         3'd3, F_SEL2, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M1,         3'd1, F_SEL1, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M2,         3'd3, F_SEL2, 8'd0,  4'd0, 3'b000));
    vecs.push_back(mk(M2|ST|CD,   3'd4, F_FETCH, 8'd12, 4'd0, 3'b010));
    for (int r = 0; r < 6; r++) begin
      vecs.push_back(mk(M1|FD, 3'd5, F_CORE, 8'd0, 4'(r), 3'b010));
      if (r < 5) vecs.push_back(mk(CD, 3'd4, F_FETCH, 8'd4, 4'(r + 1), 3'b010));
    end
    vecs.push_back(mk(CD,   3'd6, F_NONE, 8'd0, 4'd5, 3'b100));
    vecs.push_back(mk(7'd0, 3'd0, F_NONE, 8'd0, 4'd5, 3'b000));

    drive(7'd0);
    rst = 1'b1;
    tick();
    tick();
    chk_all("reset", mk(7'd0, 3'd0, F_NONE, 8'd0, 4'd0, 3'b000));
    rst = 1'b0;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Start held high while entering SEL2 must not launch a run.
    step("sedge0", mk(ST,    3'd0, F_NONE, 8'd0, 4'd5, 3'b000));
    step("sedge1", mk(ST|M2, 3'd3, F_SEL2, 8'd0, 4'd5, 3'b000));
    step("sedge2", mk(ST|M2, 3'd3, F_SEL2, 8'd0, 4'd5, 3'b000));
    step("sedge3", mk(M2,    3'd3, F_SEL2, 8'd0, 4'd5, 3'b000));
    step("sedge4", mk(M2|ST, 3'd4, F_FETCH, 8'd12, 4'd0, 3'b010));

    // Abort in CORE at row 2, coinciding with core_done.
    step("ab0", mk(FD,    3'd5, F_CORE,  8'd0, 4'd0, 3'b010));
    step("ab1", mk(CD,    3'd4, F_FETCH, 8'd4, 4'd1, 3'b010));
    step("ab2", mk(FD,    3'd5, F_CORE,  8'd0, 4'd1, 3'b010));
    step("ab3", mk(CD,    3'd4, F_FETCH, 8'd4, 4'd2, 3'b010));
    step("ab4", mk(FD,    3'd5, F_CORE,  8'd0, 4'd2, 3'b010));
    step("ab5", mk(AB|CD, 3'd0, F_NONE,  8'd0, 4'd2, 3'b000));
    step("ab6", mk(7'd0,  3'd0, F_NONE,  8'd0, 4'd2, 3'b000));

    // Watchdog: FETCH may last 16 cycles, then ERR.
    step("to0", mk(M2,    3'd3, F_SEL2,  8'd0,  4'd2, 3'b000));
    step("to1", mk(M2|ST, 3'd4, F_FETCH, 8'd12, 4'd0, 3'b010));
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("to_wait%0d.state", i), 32'(state), 32'd4);
    end
    tick();
    chk_all("to_err", mk(M2|ST, 3'd7, F_NONE, 8'd0, 4'd0, 3'b001));
    step("to_hold", mk(M2|AB, 3'd7, F_NONE, 8'd0, 4'd0, 3'b001));
    step("to_exit", mk(M2|ST, 3'd0, F_NONE, 8'd0, 4'd0, 3'b000));

    // Reset in CORE at row 3, then a fresh run.
    step("rs0", mk(M2,    3'd3, F_SEL2,  8'd0,  4'd0, 3'b000));
    step("rs1", mk(M2|ST, 3'd4, F_FETCH, 8'd12, 4'd0, 3'b010));
    for (int r = 0; r < 3; r++) begin
      step($sformatf("rs_core%0d", r), mk(FD, 3'd5, F_CORE, 8'd0, 4'(r), 3'b010));
      step($sformatf("rs_fetch%0d", r), mk(CD, 3'd4, F_FETCH, 8'd4, 4'(r + 1), 3'b010));
    end
    step("rs_core3", mk(FD, 3'd5, F_CORE, 8'd0, 4'd3, 3'b010));
    rst = 1'b1;
    step("rs_rst", mk(M2, 3'd0, F_NONE, 8'd0, 4'd0, 3'b000));
    rst = 1'b0;
    step("rs_sel", mk(M2,    3'd3, F_SEL2,  8'd0,  4'd0, 3'b000));
    step("rs_go",  mk(M2|ST, 3'd4, F_FETCH, 8'd12, 4'd0, 3'b010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
